key_entry_ctrl: RTL

//  Upstream write-front-end for the 8x4 SRAM digit-sum display block.

---
 rtl/key_entry_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/key_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_entry_ctrl
// Purpose  : Write front-end for the 8x4 SRAM digit-sum display block.
//            Synchronises and debounces nine one-hot digit keys, accepts
//            exactly one key per press and emits a one-cycle write strobe
//            with a one-hot data word and an auto-incrementing address.
// Ports    : CLK    - system clock, rising edge
//            RSTn   - asynchronous active-low reset
//            iKEY   - raw key levels (bit k = digit k+1), async to CLK
//            iCLR   - level request: reset write address to 0
//            oWR    - one-cycle write strobe
//            oD     - one-hot digit word, held until the next write
//            oA     - write address for the strobe, held likewise
//            oBUSY  - high while a press is debounced or awaiting release
// Revision : 1.0 - initial release
// ============================================================================
module key_entry_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int ADDR_W     = 3
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [8:0]        iKEY,
    input  logic              iCLR,
    output logic              oWR,
    output logic [8:0]        oD,
    output logic [ADDR_W-1:0] oA,
    output logic              oBUSY
);

    localparam int                 c_CNT_W = $clog2(DEB_CYCLES);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DEB_CYCLES - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DEB    = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;
    localparam logic [1:0] c_REL    = 2'd3;

    logic [8:0]         r_sync1;
    logic [8:0]         r_ks;
    logic [1:0]         r_state;
    logic [8:0]         r_cand;
    logic [c_CNT_W-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_wr;
    logic [8:0]         r_d;
    logic [ADDR_W-1:0]  r_a;

    logic [1:0]         w_state_nxt;
    logic [8:0]         w_cand_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_commit;
    logic               w_onehot;

    // Nonzero with no more than one bit set.
    assign w_onehot = (|r_cand) && ((r_cand & (r_cand - 9'd1)) == 9'd0);

    // Two-flop synchroniser for the asynchronous key levels.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_sync1 <= '0;
            r_ks    <= '0;
        end else begin
            r_sync1 <= iKEY;
            r_ks    <= r_sync1;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= c_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (|r_ks) begin
                    w_state_nxt = c_DEB;
                    w_cand_nxt  = r_ks;
                    w_cnt_nxt   = '0;
                end
            end
            c_DEB: begin
                if (r_ks != r_cand) begin
                    // Pattern changed: restart the stability window on it.
                    w_cand_nxt = r_ks;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == c_LAST) begin
                    w_cnt_nxt = '0;
                    if (!(|r_cand)) begin
                        w_state_nxt = c_IDLE;
                    end else if (w_onehot) begin
                        w_state_nxt = c_COMMIT;
                        w_commit    = 1'b1;
                    end else begin
                        // Multi-key chord: swallow it silently.
                        w_state_nxt = c_REL;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_COMMIT: begin
                w_state_nxt = c_REL;
                w_cnt_nxt   = '0;
            end
            c_REL: begin
                if (|r_ks) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Write address: a clear always beats the post-commit increment.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_addr <= '0;
        end else if (iCLR) begin
            r_addr <= '0;
        end else if (r_state == c_COMMIT) begin
            r_addr <= r_addr + 1'b1;
        end
    end

    // Strobe and data are loaded on entry to COMMIT so they are valid for
    // exactly the COMMIT cycle. A clear sampled on that same edge already
    // zeroes the address seen during COMMIT, so the strobe reflects it.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wr <= 1'b0;
            r_d  <= '0;
            r_a  <= '0;
        end else begin
            r_wr <= w_commit;
            if (w_commit) begin
                r_d <= r_cand;
                r_a <= iCLR ? '0 : r_addr;
            end
        end
    end

    assign oWR   = r_wr;
    assign oD    = r_d;
    assign oA    = r_a;
    assign oBUSY = (r_state != c_IDLE);

endmodule
`default_nettype wire
